// File: rtl/rr_arbiter_fsm.sv
// Four-requester round-robin arbiter with a per-grant hold limit.
// Moore grant/busy decoded from registered state; arb_valid is the Mealy strobe.
module rr_arbiter_fsm #(
   parameter int MAX_HOLD = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] req,
   input  logic       done,
   output logic [3:0] gnt,
   output logic [1:0] gnt_id,
   output logic       busy,
   output logic       arb_valid,
   output logic       timeout_err
);

   typedef enum logic [1:0] {
      IDLE    = 2'b00,
      GRANT   = 2'b01,
      RELEASE = 2'b10,
      ILLEGAL = 2'b11
   } state_t;

   localparam logic [7:0] CNT_LAST = 8'(MAX_HOLD - 1);

   state_t     state_q, state_d;
   logic [1:0] ptr_q, ptr_d;
   logic [7:0] cnt_q, cnt_d;
   logic [1:0] gnt_id_q, gnt_id_d;
   logic       timeout_err_q, timeout_err_d;

   // First set request bit scanning ptr, ptr+1, ptr+2, ptr+3 (mod 4).
   function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
      logic [1:0] idx;
      logic       found;
      rr_pick = p;
      found   = 1'b0;
      for (int k = 0; k < 4; k++) begin
         idx = p + 2'(k);
         if (!found && r[idx]) begin
            rr_pick = idx;
            found   = 1'b1;
         end
      end
   endfunction

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= IDLE;
         ptr_q         <= 2'd0;
         cnt_q         <= 8'd0;
         gnt_id_q      <= 2'd0;
         timeout_err_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         ptr_q         <= ptr_d;
         cnt_q         <= cnt_d;
         gnt_id_q      <= gnt_id_d;
         timeout_err_q <= timeout_err_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      ptr_d         = ptr_q;
      cnt_d         = cnt_q;
      gnt_id_d      = gnt_id_q;
      timeout_err_d = 1'b0;
      arb_valid     = 1'b0;
      case (state_q)
         IDLE: begin
            arb_valid = |req;
            if (|req) begin
               gnt_id_d = rr_pick(req, ptr_q);
               cnt_d    = 8'd0;
               state_d  = GRANT;
            end
         end
         GRANT: begin
            // Owner release outranks the hold limit, so no timeout is flagged then.
            if (done || !req[gnt_id_q]) begin
               state_d = RELEASE;
               ptr_d   = gnt_id_q + 2'd1;
            end else if (cnt_q == CNT_LAST) begin
               state_d       = RELEASE;
               ptr_d         = gnt_id_q + 2'd1;
               timeout_err_d = 1'b1;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         RELEASE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign busy        = (state_q == GRANT);
   assign gnt         = busy ? (4'b0001 << gnt_id_q) : 4'b0000;
   assign gnt_id      = gnt_id_q;
   assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_rr_arbiter_fsm.sv
// Table-driven bench for rr_arbiter_fsm (MAX_HOLD=4) with an expected-value queue
// and a hand-written asynchronous reset sequence.
module tb_rr_arbiter_fsm;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] req = 4'b0000;
   logic       done = 1'b0;
   logic [3:0] gnt;
   logic [1:0] gnt_id;
   logic       busy;
   logic       arb_valid;
   logic       timeout_err;

   rr_arbiter_fsm #(.MAX_HOLD(4)) dut (
      .clk(clk), .rst(rst), .req(req), .done(done),
      .gnt(gnt), .gnt_id(gnt_id), .busy(busy),
      .arb_valid(arb_valid), .timeout_err(timeout_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       rst;
      logic [3:0] req;
      logic       done;
      logic [3:0] gnt;
      logic [1:0] id;
      logic       busy;
      logic       av;
      logic       te;
   } vec_t;

   vec_t vecs[64];
   int   nvec = 0;
   vec_t exp_q[$];
   int   tests = 0;
   int   fails = 0;

   task automatic add(input logic r, input logic [3:0] rq, input logic d,
                      input logic [3:0] g, input logic [1:0] id, input logic b,
                      input logic av, input logic te);
      vecs[nvec] = '{r, rq, d, g, id, b, av, te};
      nvec++;
   endtask

   task automatic chk(input string name, input int row, input logic [3:0] act,
                      input logic [3:0] expv);
      tests++;
      if (act !== expv) begin
         fails++;
         $display("FAIL %s row %0d: got %b expected %b", name, row, act, expv);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t e;
      // rst req  done gnt   id busy av te
      add(1, 4'b0000, 0, 4'b0000, 0, 0, 0, 0);
      add(1, 4'b0001, 0, 4'b0000, 0, 0, 1, 0);  // arb_valid follows req in reset
      // single requester, done on the 3rd grant cycle
      add(0, 4'b0001, 0, 4'b0000, 0, 0, 1, 0);
      add(0, 4'b0001, 0, 4'b0001, 0, 1, 0, 0);
      add(0, 4'b0001, 0, 4'b0001, 0, 1, 0, 0);
      add(0, 4'b0001, 1, 4'b0001, 0, 1, 0, 0);
      add(0, 4'b0001, 0, 4'b0000, 0, 0, 0, 0);
      add(0, 4'b0001, 0, 4'b0000, 0, 0, 1, 0);
      add(0, 4'b0000, 0, 4'b0001, 0, 1, 0, 0);  // owner 0 drops
      add(0, 4'b1111, 0, 4'b0000, 0, 0, 0, 0);  // RELEASE: no arb_valid
      // fairness: all request, done on each grant's 2nd cycle
      add(0, 4'b1111, 0, 4'b0000, 0, 0, 1, 0);
      add(0, 4'b1111, 0, 4'b0010, 1, 1, 0, 0);
      add(0, 4'b1111, 1, 4'b0010, 1, 1, 0, 0);
      add(0, 4'b1111, 0, 4'b0000, 0, 0, 0, 0);
      add(0, 4'b1111, 0, 4'b0000, 0, 0, 1, 0);
      add(0, 4'b1111, 0, 4'b0100, 2, 1, 0, 0);
      add(0, 4'b1111, 1, 4'b0100, 2, 1, 0, 0);
      add(0, 4'b1111, 0, 4'b0000, 0, 0, 0, 0);
      add(0, 4'b1111, 0, 4'b0000, 0, 0, 1, 0);
      add(0, 4'b1111, 0, 4'b1000, 3, 1, 0, 0);
      add(0, 4'b1111, 1, 4'b1000, 3, 1, 0, 0);
      add(0, 4'b1111, 0, 4'b0000, 0, 0, 0, 0);
      add(0, 4'b1111, 0, 4'b0000, 0, 0, 1, 0);
      add(0, 4'b1111, 0, 4'b0001, 0, 1, 0, 0);
      add(0, 4'b1111, 1, 4'b0001, 0, 1, 0, 0);
      // timeout with requester 2; non-owner req changes ignored
      add(0, 4'b0100, 0, 4'b0000, 0, 0, 0, 0);
      add(0, 4'b0100, 0, 4'b0000, 0, 0, 1, 0);
      add(0, 4'b0100, 0, 4'b0100, 2, 1, 0, 0);
      add(0, 4'b0101, 0, 4'b0100, 2, 1, 0, 0);
      add(0, 4'b0111, 0, 4'b0100, 2, 1, 0, 0);
      add(0, 4'b0100, 0, 4'b0100, 2, 1, 0, 0);
      add(0, 4'b1111, 0, 4'b0000, 0, 0, 0, 1);  // timeout pulse
      add(0, 4'b1111, 0, 4'b0000, 0, 0, 1, 0);
      // ptr=3: requester 3 first; done on the limit cycle is a normal release
      add(0, 4'b1111, 0, 4'b1000, 3, 1, 0, 0);
      add(0, 4'b1111, 0, 4'b1000, 3, 1, 0, 0);
      add(0, 4'b1111, 0, 4'b1000, 3, 1, 0, 0);
      add(0, 4'b1111, 1, 4'b1000, 3, 1, 0, 0);
      add(0, 4'b1111, 0, 4'b0000, 0, 0, 0, 0);
      add(0, 4'b1111, 0, 4'b0000, 0, 0, 1, 0);
      add(0, 4'b1111, 1, 4'b0001, 0, 1, 0, 0);
      // owner 3 drops; ptr wraps to 0
      add(0, 4'b1000, 0, 4'b0000, 0, 0, 0, 0);
      add(0, 4'b1000, 0, 4'b0000, 0, 0, 1, 0);
      add(0, 4'b0000, 0, 4'b1000, 3, 1, 0, 0);
      add(0, 4'b0000, 1, 4'b0000, 0, 0, 0, 0);  // done outside GRANT
      add(0, 4'b1111, 1, 4'b0000, 0, 0, 1, 0);
      add(0, 4'b1111, 0, 4'b0001, 0, 1, 0, 0);
      add(0, 4'b1111, 1, 4'b0001, 0, 1, 0, 0);
      add(0, 4'b1111, 0, 4'b0000, 0, 0, 0, 0);
      add(0, 4'b1111, 0, 4'b0000, 0, 0, 1, 0);
      add(0, 4'b1111, 0, 4'b0010, 1, 1, 0, 0);

      for (int i = 0; i < nvec; i++) begin
         @(posedge clk);
         #1;
         rst  = vecs[i].rst;
         req  = vecs[i].req;
         done = vecs[i].done;
         exp_q.push_back(vecs[i]);
         @(negedge clk);
         if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL scoreboard row %0d: got empty queue expected one entry", i);
         end else begin
            e = exp_q.pop_front();
            chk("gnt", i, gnt, e.gnt);
            chk("busy", i, {3'b0, busy}, {3'b0, e.busy});
            chk("arb_valid", i, {3'b0, arb_valid}, {3'b0, e.av});
            chk("timeout_err", i, {3'b0, timeout_err}, {3'b0, e.te});
            if (e.busy) chk("gnt_id", i, {2'b0, gnt_id}, {2'b0, e.id});
         end
      end

      // asynchronous reset while gnt=0010
      #1 rst = 1'b1;
      #1;
      chk("rst_async_gnt", 100, gnt, 4'b0000);
      chk("rst_async_busy", 100, {3'b0, busy}, 4'b0000);
      @(posedge clk);
      #1 req = 4'b1111;
      done = 1'b0;
      chk("rst_arb_valid", 101, {3'b0, arb_valid}, 4'b0001);
      chk("rst_gnt_held", 101, gnt, 4'b0000);
      rst = 1'b0;
      @(posedge clk);
      #1;
      chk("post_rst_gnt", 102, gnt, 4'b0001);
      chk("post_rst_id", 102, {2'b0, gnt_id}, 4'b0000);
      chk("post_rst_te", 102, {3'b0, timeout_err}, 4'b0000);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/rr_arbiter_fsm.md
# rr_arbiter_fsm

Four-requester round-robin arbiter that shares one resource, such as a shared bus or functional unit, among independent clients. It is a registered FSM, with a per-grant hold limit that forcibly reclaims the resource from a client that holds it too long. It sits between the requesting blocks and the shared resource's select/enable inputs. It combines Moore outputs (grant, busy) with one Mealy output (arbitration-pending strobe).

## Interface
Parameters:
- MAX_HOLD, default 8: maximum cycles a grant may be held, legal range 2..255.

Ports (one clock; reset is asynchronous and active-high):
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-high reset
- req  input  4  request lines, bit i = requester i, level-sensitive
- done  input  1  owner releases the resource this cycle
- gnt  output  4  one-hot grant, registered (Moore)
- gnt_id  output  2  index of current owner, meaningful only while busy=1
- busy  output  1  high while in GRANT (Moore)
- arb_valid  output  1  Mealy: (state==IDLE) & |req, i.e. a grant will issue next edge
- timeout_err  output  1  one-cycle pulse when a grant is reclaimed by the hold limit

## Operation
- States:
  - IDLE (2'b00): no grant.
  - GRANT (2'b01): one owner holds the resource.
  - RELEASE (2'b10): one-cycle turnaround with gnt=0.
  - Encoding 2'b11 is illegal and goes to IDLE.
- Round-robin pointer ptr[1:0]:
  - In IDLE with |req, select the first set req bit scanning ptr, ptr+1, ptr+2, ptr+3 (mod 4).
  - Load that index into gnt_id and go to GRANT.
  - In IDLE with req==0, stay in IDLE.
- Hold counter cnt[7:0]:
  - Cleared on entry to GRANT.
  - Increments every GRANT cycle.
  - Saturates at its exit value.
- GRANT exit conditions, evaluated in this priority order:
  1. done=1, or req[gnt_id]=0 (owner dropped): normal release.
  2. cnt==MAX_HOLD-1: forced release, with timeout_err=1 on the next cycle.
- On any GRANT exit:
  - Go to RELEASE.
  - ptr <= gnt_id+1 (wraps 3 -> 0).
- RELEASE:
  - gnt=0, busy=0.
  - Unconditionally go to IDLE.
- Outputs:
  - gnt = busy ? onehot(gnt_id) : 4'b0000.
  - gnt is never more than one-hot.
- Reset:
  - Forces state=IDLE, ptr=0, cnt=0, gnt_id=0, timeout_err=0.
  - Hence gnt=0 and busy=0 immediately, without waiting for a clock edge, including mid-grant.
  - arb_valid follows req combinationally while in reset (state=IDLE).

## Timing
- Request to grant:
  - req set before edge t while in IDLE: arb_valid is high in the cycle before edge t.
  - gnt and busy are high after edge t (1-cycle latency).
- Release:
  - done sampled at edge t: gnt low after t (RELEASE).
  - IDLE after t+1.
  - Earliest next grant after t+2. Minimum gap between grants is 2 cycles.
- Hold limit:
  - Without release, the grant lasts exactly MAX_HOLD cycles.
  - timeout_err is high for exactly the first RELEASE cycle.
- done=1 and cnt==MAX_HOLD-1 in the same cycle: normal release, timeout_err stays 0.
- done while not in GRANT is ignored.
- Changes to req during GRANT by non-owners have no effect until the next IDLE.

## Test plan
- Single requester:
  - Stimulus: req=0001 from reset, done pulsed after 3 grant cycles.
  - Response: gnt=0001, gnt_id=0 for 3 cycles; then 0000 for 2 cycles; then 0001 again (req still high).
- Fairness:
  - Stimulus: req=1111 held, done pulsed on each grant's 2nd cycle.
  - Response: grant order 0,1,2,3,0; no requester served twice before the others.
- Timeout:
  - Stimulus: MAX_HOLD=4, req=0100 held, done=0.
  - Response: gnt=0100 for exactly 4 cycles; timeout_err=1 for one cycle; then requester 3 scanned first (ptr=3).
- Simultaneous done and limit:
  - Stimulus: MAX_HOLD=4, done asserted on the 4th grant cycle.
  - Response: release with timeout_err=0.
- Reset mid-grant:
  - Stimulus: rst asserted asynchronously during gnt=0010.
  - Response: gnt=0000, busy=0 before the next clock edge; after rst deasserts with req=1111, gnt=0001 (ptr=0).
- Owner drop:
  - Stimulus: req 1000 -> 0000 while granted.
  - Response: gnt low next cycle, timeout_err=0, ptr=0.
